// File: rtl/bytesub_shiftrow.sv
// AES SubBytes + ShiftRows stage, applied in place to the 16-byte state held in the shared statemt RAM.
// Optional macro BSSR_LOCK_EN adds a working_key input that gates the FSM.
module bytesub_shiftrow #(
    parameter int NB     = 4,
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
) (
    input  logic              ap_clk,
    input  logic              ap_rst_n,
    input  logic              ap_start,
    output logic              ap_done,
    output logic              ap_idle,
    output logic              ap_ready,
    output logic [ADDR_W-1:0] statemt_address0,
    output logic              statemt_ce0,
    output logic              statemt_we0,
    output logic [DATA_W-1:0] statemt_d0,
    input  logic [DATA_W-1:0] statemt_q0,
    output logic [ADDR_W-1:0] statemt_address1,
    output logic              statemt_ce1,
    output logic              statemt_we1,
    output logic [DATA_W-1:0] statemt_d1,
    input  logic [DATA_W-1:0] statemt_q1
`ifdef BSSR_LOCK_EN
    ,
    input  logic [31:0]       working_key
`endif
);

    generate
        if (NB != 4) begin : g_bad_nb
            $error("bytesub_shiftrow: only NB=4 is supported");
        end
    endgenerate

    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD,
        S_RDW,
        S_WR,
        S_DONE
    } state_t;

    state_t     state;
    logic [2:0] k;
    logic [7:0] sbuf [16];

    logic       lock_skip;
    logic       lock_xor;
    logic       lock_rev;

`ifdef BSSR_LOCK_EN
    logic       unused_key;
    assign lock_skip  = working_key[13];
    assign lock_xor   = working_key[14];
    assign lock_rev   = working_key[15];
    assign unused_key = ^{working_key[31:16], working_key[12:0]};
`else
    assign lock_skip = 1'b0;
    assign lock_xor  = 1'b0;
    assign lock_rev  = 1'b0;
`endif

    logic unused_q_hi;
    assign unused_q_hi = ^{statemt_q0[DATA_W-1:8], statemt_q1[DATA_W-1:8]};

    // Block handshake: ap_start is sampled only in IDLE; ap_done (== ap_ready) pulses
    // for exactly one cycle when the in-place update is complete.
    assign ap_idle  = (state == S_IDLE) && !ap_start;
    assign ap_ready = ap_done;

    function automatic logic [ADDR_W-1:0] word_addr(input logic [2:0] pair, input logic lane);
        return ADDR_W'({pair, lane});
    endfunction

    // ShiftRows source of output byte r+4c is r + 4*((c+r) mod 4).
    function automatic logic [3:0] src_idx(input logic [3:0] idx);
        return {idx[3:2] + idx[1:0], idx[1:0]};
    endfunction

    logic [2:0] nxt_k;
    logic [2:0] wr_pair;
    logic [7:0] wr_mask;
    logic [7:0] new0;
    logic [7:0] new1;

    // The first written pair (0 or 7) never sources bytes 14/15, which land in the
    // buffer on the same edge that registers that pair's data.
    always_comb begin
        nxt_k   = (state == S_RDW) ? 3'd0 : k + 3'd1;
        wr_pair = lock_rev ? ~nxt_k : nxt_k;
        wr_mask = lock_xor ? 8'h5a : 8'h00;
        new0    = SBOX[sbuf[src_idx({wr_pair, 1'b0})]] ^ wr_mask;
        new1    = SBOX[sbuf[src_idx({wr_pair, 1'b1})]] ^ wr_mask;
    end

    always_ff @(posedge ap_clk) begin
        if (state == S_RD && k != 3'd0) begin
            sbuf[{k - 3'd1, 1'b0}] <= statemt_q0[7:0];
            sbuf[{k - 3'd1, 1'b1}] <= statemt_q1[7:0];
        end else if (state == S_RDW) begin
            sbuf[14] <= statemt_q0[7:0];
            sbuf[15] <= statemt_q1[7:0];
        end
    end

    always_ff @(posedge ap_clk) begin
        if (!ap_rst_n) begin
            state            <= S_IDLE;
            k                <= 3'd0;
            ap_done          <= 1'b0;
            statemt_ce0      <= 1'b0;
            statemt_we0      <= 1'b0;
            statemt_address0 <= '0;
            statemt_d0       <= '0;
            statemt_ce1      <= 1'b0;
            statemt_we1      <= 1'b0;
            statemt_address1 <= '0;
            statemt_d1       <= '0;
        end else begin
            ap_done          <= 1'b0;
            statemt_ce0      <= 1'b0;
            statemt_we0      <= 1'b0;
            statemt_address0 <= '0;
            statemt_d0       <= '0;
            statemt_ce1      <= 1'b0;
            statemt_we1      <= 1'b0;
            statemt_address1 <= '0;
            statemt_d1       <= '0;
            case (state)
                S_IDLE: begin
                    if (ap_start) begin
                        state            <= S_RD;
                        k                <= 3'd0;
                        statemt_ce0      <= 1'b1;
                        statemt_ce1      <= 1'b1;
                        statemt_address0 <= word_addr(3'd0, 1'b0);
                        statemt_address1 <= word_addr(3'd0, 1'b1);
                    end
                end
                S_RD: begin
                    if (k == 3'd7) begin
                        state <= S_RDW;
                    end else begin
                        k                <= nxt_k;
                        statemt_ce0      <= 1'b1;
                        statemt_ce1      <= 1'b1;
                        statemt_address0 <= word_addr(nxt_k, 1'b0);
                        statemt_address1 <= word_addr(nxt_k, 1'b1);
                    end
                end
                S_RDW: begin
                    if (lock_skip) begin
                        state   <= S_DONE;
                        ap_done <= 1'b1;
                    end else begin
                        state            <= S_WR;
                        k                <= 3'd0;
                        statemt_ce0      <= 1'b1;
                        statemt_we0      <= 1'b1;
                        statemt_address0 <= word_addr(wr_pair, 1'b0);
                        statemt_d0       <= DATA_W'(new0);
                        statemt_ce1      <= 1'b1;
                        statemt_we1      <= 1'b1;
                        statemt_address1 <= word_addr(wr_pair, 1'b1);
                        statemt_d1       <= DATA_W'(new1);
                    end
                end
                S_WR: begin
                    if (k == 3'd7) begin
                        state   <= S_DONE;
                        ap_done <= 1'b1;
                    end else begin
                        k                <= nxt_k;
                        statemt_ce0      <= 1'b1;
                        statemt_we0      <= 1'b1;
                        statemt_address0 <= word_addr(wr_pair, 1'b0);
                        statemt_d0       <= DATA_W'(new0);
                        statemt_ce1      <= 1'b1;
                        statemt_we1      <= 1'b1;
                        statemt_address1 <= word_addr(wr_pair, 1'b1);
                        statemt_d1       <= DATA_W'(new1);
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
